// File: rtl/input_debouncer.sv
// Switch/button debouncer: two-flop synchronizer followed by a four-state
// qualification FSM that accepts a new level only after it has held for
// STABLE_CYCLES synchronized cycles.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   d    - raw asynchronous input
//   q    - debounced registered level
//   rise - one-cycle registered pulse when q goes 0 -> 1
//   fall - one-cycle registered pulse when q goes 1 -> 0
//   busy - high while a level change is being qualified (decoded from state)
module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        WAIT_H = 2'd1,
        HIGH   = 2'd2,
        WAIT_L = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    // Only the second synchronizer stage is allowed to feed the FSM.
    assign sync = s2;

    // busy is a pure decode of the qualifying states.
    assign busy = (state == WAIT_H) || (state == WAIT_L);

    // Synchronizer, qualification FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= LOW;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                LOW: begin
                    cnt <= '0;
                    if (sync) begin
                        state <= WAIT_H;
                    end
                end
                WAIT_H: begin
                    if (!sync) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HIGH;
                        cnt   <= '0;
                        q     <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    cnt <= '0;
                    if (!sync) begin
                        state <= WAIT_L;
                    end
                end
                WAIT_L: begin
                    if (sync) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOW;
                        cnt   <= '0;
                        q     <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with STABLE_CYCLES=4.
// Reference model: q flips once the synchronized input has differed from q
// for STABLE_CYCLES+1 consecutive clock edges; busy means a run is in progress.
module tb_input_debouncer;

    localparam int unsigned SC = 4;

    logic clk = 1'b0;
    logic rst;
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    int total = 0;
    int bad   = 0;

    input_debouncer #(.STABLE_CYCLES(SC), .CNT_W(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: two-sample delay line plus a run-length of disagreement.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_q = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    int   m_run = 0;
    logic m_busy;
    assign m_busy = (m_run != 0);

    always @(posedge clk) begin
        logic sv;
        if (!rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_q = 1'b0;
            m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
        end else begin
            sv     = m_s2;
            m_s2   = m_s1;
            m_s1   = d;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (sv != m_q) begin
                m_run = m_run + 1;
                if (m_run == int'(SC) + 1) begin
                    m_q    = sv;
                    m_rise = sv;
                    m_fall = ~sv;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    // Drive inputs away from the edge, advance one edge, settle before sampling.
    task automatic tick(input logic dv, input logic rv);
        d   = dv;
        rst = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            total++;
            if ({q, rise, fall, busy} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outputs: got q/rise/fall/busy=%b want 0000", {q, rise, fall, busy});
            end
            total++;
            if (dut.cnt !== 16'd0) begin
                bad++;
                $display("FAIL reset_cnt: got %0d want 0", dut.cnt);
            end
        end
        // Edge 0 is the first edge sampling rst=1, which also loads d=1 into s1.
        for (int e = 0; e < 10; e++) begin
            tick(1'b1, 1'b1);
            total++;
            if (q !== (e >= 6)) begin
                bad++;
                $display("FAIL release_q edge %0d: got %b want %b", e, q, (e >= 6));
            end
            total++;
            if (rise !== (e == 6) || fall !== 1'b0) begin
                bad++;
                $display("FAIL release_pulse edge %0d: got rise=%b fall=%b want rise=%b fall=0", e, rise, fall, (e == 6));
            end
        end
    endtask

    task automatic test_glitch;
        logic busy_seen, rise_seen, q_seen;
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
        total++;
        if (q !== 1'b0) begin
            bad++;
            $display("FAIL glitch_setup_q: got %b want 0", q);
        end
        busy_seen = 1'b0; rise_seen = 1'b0; q_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick((i < 3) ? 1'b1 : 1'b0, 1'b1);
            busy_seen |= busy;
            rise_seen |= rise;
            q_seen    |= q;
        end
        total++;
        if (q_seen !== 1'b0 || rise_seen !== 1'b0) begin
            bad++;
            $display("FAIL glitch_no_change: got q_seen=%b rise_seen=%b want 0 0", q_seen, rise_seen);
        end
        total++;
        if (busy_seen !== 1'b1) begin
            bad++;
            $display("FAIL glitch_busy: got busy_seen=%b want 1", busy_seen);
        end
        total++;
        if (busy !== 1'b0 || q !== 1'b0) begin
            bad++;
            $display("FAIL glitch_end_low: got busy=%b q=%b want 0 0", busy, q);
        end
    endtask

    task automatic test_fall;
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1);
        total++;
        if (q !== 1'b1) begin
            bad++;
            $display("FAIL fall_setup_q: got %b want 1", q);
        end
        for (int e = 0; e < 10; e++) begin
            tick(1'b0, 1'b1);
            total++;
            if (q !== (e < 6)) begin
                bad++;
                $display("FAIL fall_q edge %0d: got %b want %b", e, q, (e < 6));
            end
            total++;
            if (fall !== (e == 6) || rise !== 1'b0) begin
                bad++;
                $display("FAIL fall_pulse edge %0d: got fall=%b rise=%b want fall=%b rise=0", e, fall, rise, (e == 6));
            end
        end
    endtask

    task automatic test_reset_wait;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        total++;
        if (busy !== 1'b1 || q !== 1'b0) begin
            bad++;
            $display("FAIL rstwait_setup: got busy=%b q=%b want 1 0", busy, q);
        end
        tick(1'b1, 1'b0);
        total++;
        if ({q, busy, rise, fall} !== 4'b0000) begin
            bad++;
            $display("FAIL rstwait_outputs: got q/busy/rise/fall=%b want 0000", {q, busy, rise, fall});
        end
        total++;
        if (dut.cnt !== 16'd0) begin
            bad++;
            $display("FAIL rstwait_cnt: got %0d want 0", dut.cnt);
        end
    endtask

    task automatic test_reset_high;
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1);
        total++;
        if (q !== 1'b1) begin
            bad++;
            $display("FAIL rsthigh_setup_q: got %b want 1", q);
        end
        tick(1'b1, 1'b0);
        total++;
        if (q !== 1'b0 || fall !== 1'b0) begin
            bad++;
            $display("FAIL rsthigh: got q=%b fall=%b want 0 0", q, fall);
        end
    endtask

    task automatic test_toggle;
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            tick(1'(i % 2), 1'b1);
            total++;
            if (q !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
                bad++;
                $display("FAIL toggle cycle %0d: got q=%b rise=%b fall=%b want 0 0 0", i, q, rise, fall);
            end
        end
    endtask

    task automatic test_random;
        logic dv, rv;
        int   hold;
        dv = 1'b0;
        for (int i = 0; i < 3000; i += hold) begin
            hold = int'($urandom_range(1, 9));
            dv   = ~dv;
            for (int k = 0; k < hold; k++) begin
                rv = ($urandom_range(0, 199) != 0);
                tick(dv, rv);
                total++;
                if (q !== m_q || rise !== m_rise || fall !== m_fall || busy !== m_busy) begin
                    bad++;
                    $display("FAIL random cycle %0d: got q/rise/fall/busy=%b%b%b%b want %b%b%b%b",
                             i + k, q, rise, fall, busy, m_q, m_rise, m_fall, m_busy);
                end
                total++;
                if (rise === 1'b1 && fall === 1'b1) begin
                    bad++;
                    $display("FAIL random_exclusive cycle %0d: got rise=1 fall=1 want not both", i + k);
                end
            end
        end
    endtask

    initial begin
        d   = 1'b1;
        rst = 1'b0;
        test_reset;
        test_glitch;
        test_fall;
        test_reset_wait;
        test_reset_high;
        test_toggle;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
